// File: rtl/xz_scrub_fifo_pkg.sv
// Shared types and constants for the X/Z scrubbing capture FIFO.
// Default geometry matches the 8-bit x 32 test memory images.
package xz_scrub_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 32;

  localparam logic [7:0] XZ_CNT_MAX = 8'hFF;

  typedef struct packed {
    bit                 xz;
    bit [WIDTH_DEF-1:0] data;
  } xz_entry_t;

  // Saturating increment for the tagged-push counter.
  function automatic logic [7:0] xz_cnt_inc(input logic [7:0] cnt);
    logic [7:0] res;
    if (cnt == XZ_CNT_MAX) begin
      res = cnt;
    end else begin
      res = cnt + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/xz_scrub_fifo_if.sv
// Handshake bundle between a 4-state byte producer, the scrub FIFO and its
// 2-state consumer; clk/rst stay outside the bundle.
interface xz_scrub_fifo_if
  import xz_scrub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  bit   [WIDTH-1:0] out_data;
  bit               out_xz;
  logic [CW-1:0]    count;
  logic [7:0]       xz_err_cnt;
  logic             xz_sticky;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_xz, count, xz_err_cnt, xz_sticky
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_xz, count, xz_err_cnt, xz_sticky
  );

endinterface

// File: rtl/xz_scrub_fifo_detect.sv
// Combinational 4-state to 2-state converter: 1 stays 1, everything else
// becomes 0, and any bit that is neither a clean 0 nor 1 raises xz.
module xz_detect
  import xz_scrub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] raw,
  output bit   [WIDTH-1:0] clean,
  output bit               xz
);

  // Per-bit case-equality classification of the incoming byte.
  always_comb begin
    clean = {WIDTH{1'b0}};
    xz    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (raw[i] === 1'b1) begin
        clean[i] = 1'b1;
      end else if (raw[i] === 1'b0) begin
        clean[i] = 1'b0;
      end else begin
        clean[i] = 1'b0;
        xz       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xz_scrub_fifo.sv
// First-word-fall-through FIFO storing scrubbed 2-state data with a per-entry
// X/Z tag, plus a saturating tagged-push counter and sticky flag.
module xz_scrub_fifo
  import xz_scrub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic            clk,
  input logic            rst,
  xz_scrub_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    bit             xz;
    bit [WIDTH-1:0] data;
  } entry_t;

  entry_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_s;
  logic [AW-1:0] rd_ptr_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic          in_ready_r;
  logic          out_valid_r;
  entry_t        head_r;
  entry_t        head_s;
  entry_t        in_entry_s;
  logic [7:0]    err_cnt_r;
  logic          sticky_r;
  logic          push_s;
  logic          pop_s;
  bit [WIDTH-1:0] clean_s;
  bit            xz_s;

  xz_detect #(.WIDTH(WIDTH)) u_detect (
    .raw   (bus.in_data),
    .clean (clean_s),
    .xz    (xz_s)
  );

  assign in_entry_s = {xz_s, clean_s};
  assign push_s     = bus.in_valid && in_ready_r;
  assign pop_s      = bus.out_ready && out_valid_r;

  // Next pointers, occupancy and the entry that will sit at the head after this edge.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    count_s  = count_r;
    head_s   = head_r;

    if (push_s) begin
      wr_ptr_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase

    // The new head is the incoming entry when it lands exactly where rd points next.
    if (push_s && (wr_ptr_r == rd_ptr_s)) begin
      head_s = in_entry_s;
    end else if (count_s != CNT_ZERO) begin
      head_s = mem_r[rd_ptr_s];
    end else begin
      head_s = head_r;
    end
  end

  // Control state, registered head and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_r      <= {1'b0, {WIDTH{1'b0}}};
      err_cnt_r   <= 8'd0;
      sticky_r    <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      in_ready_r  <= (count_s != CNT_FULL);
      out_valid_r <= (count_s != CNT_ZERO);
      head_r      <= head_s;
      if (push_s && xz_s) begin
        err_cnt_r <= xz_cnt_inc(err_cnt_r);
        sticky_r  <= 1'b1;
      end else begin
        err_cnt_r <= err_cnt_r;
        sticky_r  <= sticky_r;
      end
    end
  end

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= in_entry_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = head_r.data;
  assign bus.out_xz     = head_r.xz;
  assign bus.count      = count_r;
  assign bus.xz_err_cnt = err_cnt_r;
  assign bus.xz_sticky  = sticky_r;

endmodule

// File: tb/tb_xz_scrub_fifo.sv
// Directed self-checking bench for xz_scrub_fifo: one task per scenario,
// each comparing DUT outputs against values derived from its own stimulus.
module tb_xz_scrub_fifo;
  import xz_scrub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_err;
  logic       exp_sticky;

  xz_scrub_fifo_if #(.WIDTH(8), .DEPTH(32)) bus ();

  xz_scrub_fifo #(.WIDTH(8), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference conversion: only a definite 1 survives as 1.
  function automatic logic [7:0] conv(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (v[i] === 1'b1);
    return r;
  endfunction

  function automatic logic has_xz(input logic [7:0] v);
    return (^v === 1'bx);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_push(input logic [7:0] v);
    if (has_xz(v)) begin
      exp_sticky = 1'b1;
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_err = 8'd0; exp_sticky = 1'b0;
    n_checks++;
    if ({bus.count, bus.in_ready, bus.out_valid, bus.xz_err_cnt, bus.xz_sticky, bus.out_data, bus.out_xz}
        !== {6'd0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got count=%0d in_ready=%b out_valid=%b err=%0d sticky=%b data=%h xz=%b, want 0 1 0 0 0 00 0",
               bus.count, bus.in_ready, bus.out_valid, bus.xz_err_cnt, bus.xz_sticky, bus.out_data, bus.out_xz);
    end
  endtask

  task automatic test_basic();
    logic [7:0] vec [3];
    vec = '{8'h00, 8'h01, 8'hA5};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = vec[i];
      tick();
      note_push(vec[i]);
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_xz} !== {1'b1, vec[i], 1'b0}) begin
        n_errors++;
        $display("FAIL basic_head[%0d]: got v=%b d=%h xz=%b, want 1 %h 0", i, bus.out_valid, bus.out_data, bus.out_xz, vec[i]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    // Empty again: head data must hold the last popped byte.
    n_checks++;
    if ({bus.out_valid, bus.count, bus.out_data, bus.out_xz, bus.xz_err_cnt} !== {1'b0, 6'd0, 8'hA5, 1'b0, 8'd0}) begin
      n_errors++;
      $display("FAIL basic_empty_hold: got v=%b cnt=%0d d=%h xz=%b err=%0d, want 0 0 a5 0 0",
               bus.out_valid, bus.count, bus.out_data, bus.out_xz, bus.xz_err_cnt);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_xz();
    logic [7:0] vec [3];
    // Hand values: 00, 00, 8'b1000_1010 each tagged.
    vec = '{8'hzz, 8'hxx, 8'b1x0z_1010};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = vec[i];
      tick();
      note_push(vec[i]);
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_xz} !== {1'b1, conv(vec[i]), has_xz(vec[i])}) begin
        n_errors++;
        $display("FAIL xz_head[%0d]: got v=%b d=%h xz=%b, want 1 %h %b",
                 i, bus.out_valid, bus.out_data, bus.out_xz, conv(vec[i]), has_xz(vec[i]));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.xz_err_cnt, bus.xz_sticky} !== {exp_err, exp_sticky}) begin
      n_errors++;
      $display("FAIL xz_counters: got err=%0d sticky=%b, want %0d %b", bus.xz_err_cnt, bus.xz_sticky, exp_err, exp_sticky);
    end
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i);
      tick();
    end
    n_checks++;
    if ({bus.count, bus.in_ready, bus.out_valid, bus.out_data} !== {6'd32, 1'b0, 1'b1, 8'h00}) begin
      n_errors++;
      $display("FAIL full_state: got cnt=%0d rdy=%b v=%b d=%h, want 32 0 1 00", bus.count, bus.in_ready, bus.out_valid, bus.out_data);
    end
    bus.in_data = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.count, bus.in_ready, bus.out_data} !== {6'd32, 1'b0, 8'h00}) begin
      n_errors++;
      $display("FAIL full_drop: got cnt=%0d rdy=%b d=%h, want 32 0 00", bus.count, bus.in_ready, bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 8'(i)}) begin
        n_errors++;
        $display("FAIL full_drain[%0d]: got v=%b d=%h, want 1 %h", i, bus.out_valid, bus.out_data, 8'(i));
      end
      tick();
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.count, bus.out_valid, bus.in_ready} !== {6'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL full_drained: got cnt=%0d v=%b rdy=%b, want 0 0 1", bus.count, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [$];
    logic [7:0] v;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 31; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i + 100);
      q.push_back(8'(i + 100));
      tick();
    end
    n_checks++;
    if (bus.count !== 6'd31) begin
      n_errors++;
      $display("FAIL b2b_fill: got cnt=%0d, want 31", bus.count);
    end
    for (int i = 0; i < 40; i++) begin
      v = 8'(i + 150);
      bus.in_valid = 1'b1; bus.in_data = v; bus.out_ready = 1'b1;
      n_checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, q[0]}) begin
        n_errors++;
        $display("FAIL b2b_head[%0d]: got v=%b d=%h, want 1 %h", i, bus.out_valid, bus.out_data, q[0]);
      end
      tick();
      void'(q.pop_front());
      q.push_back(v);
      n_checks++;
      if (bus.count !== 6'd31) begin
        n_errors++;
        $display("FAIL b2b_count[%0d]: got cnt=%0d, want 31", i, bus.count);
      end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 31; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, q[0]}) begin
        n_errors++;
        $display("FAIL b2b_drain[%0d]: got v=%b d=%h, want 1 %h", i, bus.out_valid, bus.out_data, q[0]);
      end
      tick();
      void'(q.pop_front());
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.count, bus.out_valid} !== {6'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_empty: got cnt=%0d v=%b, want 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_saturate();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hxx;
    for (int i = 0; i < 300; i++) begin
      tick();
      note_push(8'hxx);
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.xz_err_cnt, bus.xz_sticky} !== {exp_err, exp_sticky}) begin
      n_errors++;
      $display("FAIL sat_counter: got err=%0d sticky=%b, want %0d %b", bus.xz_err_cnt, bus.xz_sticky, exp_err, exp_sticky);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 8'd0; exp_sticky = 1'b0;
    n_checks++;
    if ({bus.count, bus.in_ready, bus.out_valid, bus.xz_err_cnt, bus.xz_sticky, bus.out_data, bus.out_xz}
        !== {6'd0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 1'b0}) begin
      n_errors++;
      $display("FAIL sat_reset: got cnt=%0d rdy=%b v=%b err=%0d sticky=%b d=%h xz=%b, want 0 1 0 0 0 00 0",
               bus.count, bus.in_ready, bus.out_valid, bus.xz_err_cnt, bus.xz_sticky, bus.out_data, bus.out_xz);
    end
  endtask

  task automatic test_reset_collision();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i);
      tick();
    end
    n_checks++;
    if (bus.count !== 6'd5) begin
      n_errors++;
      $display("FAIL coll_fill: got cnt=%0d, want 5", bus.count);
    end
    bus.in_data = 8'hAA; bus.out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.count, bus.out_valid, bus.in_ready, bus.out_data} !== {6'd0, 1'b0, 1'b1, 8'h00}) begin
      n_errors++;
      $display("FAIL coll_reset: got cnt=%0d v=%b rdy=%b d=%h, want 0 0 1 00", bus.count, bus.out_valid, bus.in_ready, bus.out_data);
    end
    // Pop requested while empty: only the push may land, no bypass.
    bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.count, bus.out_valid, bus.out_data, bus.out_xz} !== {6'd1, 1'b1, 8'h3C, 1'b0}) begin
      n_errors++;
      $display("FAIL coll_push: got cnt=%0d v=%b d=%h xz=%b, want 1 1 3c 0", bus.count, bus.out_valid, bus.out_data, bus.out_xz);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_xz();
    test_full();
    test_back_to_back();
    test_saturate();
    test_reset_collision();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/xz_scrub_fifo.md
# xz_scrub_fifo

Upstream capture stage for the 2-state test memories (8-bit × 32 images) used across the datatype benches. Accepts a 4-state byte stream over a valid/ready handshake and converts each byte to 2-state using the same rule as a 4-state-to-2-state assignment: X→0, Z→0. It tags every entry that contained an unknown bit and buffers entries in a 32-deep FIFO. Downstream consumers (memory loaders, scoreboards) see only 2-state data plus a per-entry `xz` tag, so initialization failures stay visible after conversion.

## Interface
Parameters:
- `WIDTH`, 8, data width in bits
- `DEPTH`, 32, FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream data valid; always driven to a known 0/1
- `in_ready`  out  1  upstream may push; equals `!full`
- `in_data`  in  logic [WIDTH-1:0]  4-state input byte
- `out_valid`  out  1  FIFO head valid; equals `!empty`
- `out_ready`  in  1  downstream pops the head
- `out_data`  out  bit [WIDTH-1:0]  2-state head data
- `out_xz`  out  1  head entry had ≥1 X/Z bit on input
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `xz_err_cnt`  out  8  saturating count of tagged pushes
- `xz_sticky`  out  1  set on the first tagged push; cleared only by `rst`

## Operation
- Push occurs when `in_valid && in_ready` at a rising edge.
- Pop occurs when `out_valid && out_ready` at a rising edge.
- Conversion is per bit: `1`→1, `0`→0, `X`→0, `Z`→0.
- `xz` tag = 1 if any bit of `in_data` is X or Z, evaluated on the value sampled at the push edge.
- Stored entry = {xz, converted data}. The tag is stored per entry and travels with its data.
- On each tagged push, `xz_err_cnt` increments, saturating at 255. Untagged pushes leave it unchanged.
- `xz_sticky` is set together with the first tagged push.
- FIFO ordering is strict first-in, first-out.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from DEPTH-1 to 0.
- Full and empty are derived from `count`, not from pointer compare.
- Full (`count == DEPTH`): `in_ready` = 0. Push attempts are ignored and nothing changes.
- Empty (`count == 0`): `out_valid` = 0. Pop attempts are ignored, and `out_data`/`out_xz` hold their last values.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, both take effect and `count` is unchanged.
  - When count == 0, only the push takes effect; there is no bypass.
  - When count == DEPTH, only the pop takes effect, since `in_ready` is already 0.

## Timing
- Reset (synchronous, active-high): `count`=0, pointers=0, `out_valid`=0, `in_ready`=1, `xz_err_cnt`=0, `xz_sticky`=0, `out_data`=0, `out_xz`=0.
- Storage array contents are not reset; they are 2-state, so they read 0 before the first write.
- `rst` asserted mid-stream empties the FIFO at that edge. Any push or pop on the same edge is discarded.
- Outputs are first-word-fall-through. A push into an empty FIFO at edge N gives `out_valid`=1 and valid `out_data`/`out_xz` after edge N. Latency is 1 cycle.
- After a pop at edge N, the next entry appears on `out_data` after edge N. A back-to-back stream sustains 1 entry per cycle.
- `in_ready` and `out_valid` are functions of `count` only. Neither depends combinationally on `in_valid` or `out_ready`.
- `count`, `xz_err_cnt` and `xz_sticky` update at the same edge as the push or pop that causes the change.

## Structure
- Package `xz_scrub_pkg` contains:
  - `WIDTH_DEF` = 8 and `DEPTH_DEF` = 32
  - `typedef struct packed { bit xz; bit [WIDTH_DEF-1:0] data; } xz_entry_t`
  - `XZ_CNT_MAX` = 8'hFF
- Sub-module `xz_detect` (combinational) takes `logic [WIDTH-1:0]` in and produces `bit [WIDTH-1:0]` out plus a `bit xz` flag. Detection is per bit with `===` against 1/0, so the check is unambiguous in simulation.
- The top level holds the storage array, pointers, count, error counter and sticky flag.

## Test plan
- Reset, then push 8'h00, 8'h01, 8'hA5 with `out_ready`=1 → `out_data` = 00, 01, A5 in order, `out_xz`=0 throughout, `xz_err_cnt`=0.
- Push 8'hzz, then 8'hxx, then 8'b1x0z_1010 → `out_data` = 00, 00, 8'b1000_1010, each with `out_xz`=1. Final `xz_err_cnt`=3 and `xz_sticky`=1.
- Push 32 entries 0..31 with `out_ready`=0 → `count`=32 and `in_ready`=0. A 33rd push of 8'hFF is dropped. Draining then yields 0..31 exactly and `count`=0.
- Hold `count`=31, then wrap the pointers by pushing 40 and popping 40 with simultaneous push/pop every cycle → `count` stays 31, data order is preserved, and there is no gap in `out_valid`.
- Push 300 bytes of all-X → `xz_err_cnt` saturates at 255 and `xz_sticky`=1. Assert `rst` for one cycle → every output returns to its reset value.
- With `count`=5, assert `rst` in the same cycle as a push and a pop → after that edge `count`=0 and `out_valid`=0. The next push of 8'h3C appears 1 cycle later with `out_xz`=0.
